// File: rtl/ma_stage.sv
`default_nettype none
// ============================================================================
// Module   : ma_stage
// Purpose  : RV32I memory-access stage: data-memory req/ack handshake,
//            store lane steering, load formatting and MA->WB registers.
// Revision : 1.0 - initial release
// ============================================================================
module ma_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    input  logic        stall,
    input  logic        rst_pipe,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dc_stall,
    output logic        ma_misalign,
    output logic [4:0]  rd_adr_wb,
    output logic        wbk_rd_reg_wb,
    output logic [31:0] wbk_data_wb,
    output logic [31:0] wbk_data_wb2
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;
    logic [31:0] r_ld_hold;
    logic [4:0]  r_rd_adr_wb;
    logic        r_wbk_rd_reg_wb;
    logic [31:0] r_wbk_data_wb;
    logic [31:0] r_wbk_data_wb2;

    logic        w_is_ldst;
    logic        w_word;
    logic        w_half;
    logic        w_misalign;
    logic        w_memop;
    logic        w_req;
    logic        w_advance;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_src;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_fmt;
    logic [31:0] w_wbk_data;

    // Codes 011/110/111 fall into the word class through bit 1.
    assign w_off      = rd_data_ma[1:0];
    assign w_word     = ldst_code_ma[1];
    assign w_half     = ~ldst_code_ma[1] & ldst_code_ma[0];
    assign w_is_ldst  = cmd_ld_ma | cmd_st_ma;
    assign w_misalign = w_is_ldst & ((w_half & w_off[0]) | (w_word & (w_off != 2'b00)));
    assign w_memop    = w_is_ldst & ~w_misalign;
    assign w_req      = w_memop & (r_state != S_DONE);
    assign w_advance  = ~stall & ~dc_stall;

    assign dmem_req    = w_req;
    assign dmem_we     = w_memop & cmd_st_ma;
    assign dmem_adr    = w_memop ? rd_data_ma[31:2] : 30'd0;
    assign dmem_be     = w_memop ? w_be : 4'd0;
    assign dmem_wdata  = w_memop ? w_wdata : 32'd0;
    assign dc_stall    = w_req & ~dmem_ack;
    assign ma_misalign = w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = st_data_ma;
        if (cmd_st_ma && !w_word) begin
            if (w_half) begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data_ma[15:0]}};
            end else begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{st_data_ma[7:0]}};
            end
        end
    end

    // Once a stall swallowed the ack, the captured word replaces the bus.
    assign w_ld_src  = (r_state == S_DONE) ? r_ld_hold : dmem_rdata;
    assign w_ld_half = w_off[1] ? w_ld_src[31:16] : w_ld_src[15:0];

    always_comb begin
        case (w_off)
            2'd0:    w_ld_byte = w_ld_src[7:0];
            2'd1:    w_ld_byte = w_ld_src[15:8];
            2'd2:    w_ld_byte = w_ld_src[23:16];
            default: w_ld_byte = w_ld_src[31:24];
        endcase
    end

    always_comb begin
        if (w_word)
            w_ld_fmt = w_ld_src;
        else if (w_half)
            w_ld_fmt = {{16{~ldst_code_ma[2] & w_ld_half[15]}}, w_ld_half};
        else
            w_ld_fmt = {{24{~ldst_code_ma[2] & w_ld_byte[7]}}, w_ld_byte};
    end

    assign w_wbk_data = cmd_ld_ma ? w_ld_fmt : rd_data_ma;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (!w_memop) begin
                    w_state_nxt = S_IDLE;
                end else if (!dmem_ack) begin
                    w_state_nxt = S_WAIT;
                end else if (stall) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (!stall || !w_memop)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_ld_hold       <= 32'd0;
            r_rd_adr_wb     <= 5'd0;
            r_wbk_rd_reg_wb <= 1'b0;
            r_wbk_data_wb   <= 32'd0;
            r_wbk_data_wb2  <= 32'd0;
        end else if (rst_pipe) begin
            r_state         <= S_IDLE;
            r_ld_hold       <= 32'd0;
            r_rd_adr_wb     <= 5'd0;
            r_wbk_rd_reg_wb <= 1'b0;
            r_wbk_data_wb   <= 32'd0;
            r_wbk_data_wb2  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture)
                r_ld_hold <= dmem_rdata;
            if (w_advance) begin
                r_rd_adr_wb     <= rd_adr_ma;
                r_wbk_rd_reg_wb <= wbk_rd_reg_ma & ~w_misalign;
                r_wbk_data_wb   <= w_wbk_data;
                r_wbk_data_wb2  <= r_wbk_data_wb;
            end
        end
    end

    assign rd_adr_wb     = r_rd_adr_wb;
    assign wbk_rd_reg_wb = r_wbk_rd_reg_wb;
    assign wbk_data_wb   = r_wbk_data_wb;
    assign wbk_data_wb2  = r_wbk_data_wb2;

endmodule
`default_nettype wire

// File: tb/tb_ma_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_stage
// Purpose  : Self-checking bench for ma_stage: vector table, random ops
//            against a reference model, and multi-cycle handshake sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_ld_ma = 1'b0, cmd_st_ma = 1'b0;
    logic [4:0]  rd_adr_ma = '0;
    logic [31:0] rd_data_ma = '0, st_data_ma = '0;
    logic        wbk_rd_reg_ma = 1'b0;
    logic [2:0]  ldst_code_ma = '0;
    logic        stall = 1'b0, rst_pipe = 1'b0;
    logic        dmem_req, dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dc_stall, ma_misalign;
    logic [4:0]  rd_adr_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] wbk_data_wb, wbk_data_wb2;

    always #5 clk = ~clk;

    ma_stage dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
        .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma),
        .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma), .stall(stall), .rst_pipe(rst_pipe),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dc_stall(dc_stall), .ma_misalign(ma_misalign),
        .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
        .wbk_data_wb(wbk_data_wb), .wbk_data_wb2(wbk_data_wb2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] code,
                            input logic [31:0] adr, input logic [31:0] sd,
                            input logic wbk, input logic [4:0] rd);
        cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code;
        rd_data_ma = adr; st_data_ma = sd; wbk_rd_reg_ma = wbk; rd_adr_ma = rd;
    endtask

    // Reference model: access size in bytes, lane arithmetic via shifts/multiplies.
    function automatic void model(input logic ld, input logic st, input logic [2:0] code,
                                  input logic [31:0] adr, input logic [31:0] sd,
                                  input logic [31:0] rdat, input logic wbk,
                                  output logic mis, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] wv,
                                  output logic rdf);
        int size, off;
        logic [31:0] v;
        size = code[1] ? 4 : (code[0] ? 2 : 1);
        off  = int'(adr % 4);
        mis  = (ld || st) && ((adr % size) != 0);
        if (!(ld || st) || mis) be = 4'd0;
        else if (ld)            be = 4'hF;
        else                    be = 4'(((1 << size) - 1) << off);
        if (size == 1)      wd = sd[7:0] * 32'h01010101;
        else if (size == 2) wd = sd[15:0] * 32'h00010001;
        else                wd = sd;
        v = rdat >> (8 * off);
        if (size == 1) begin
            v = v & 32'hFF;
            if (!code[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!code[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        wv  = ld ? v : adr;
        rdf = wbk && !mis;
    endfunction

    typedef struct {
        logic        ld, st;
        logic [2:0]  code;
        logic [31:0] adr, sd, rdat;
        logic        wbk;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd, wv;
        logic        rdf, cw;
    } vec_t;

    vec_t vt[15];

    logic        rl, rs, rwbk, rmis, rrdf, memop;
    logic [2:0]  rcode;
    logic [31:0] radr, rsd, rdat, rwd, rwv, prev_wb;
    logic [3:0]  rbe;
    logic [4:0]  rrd;
    int          lat, ncyc, nstall, nhs;

    initial begin
        //             ld  st  code    adr           sd            rdat          wbk mis be      wd            wv            rdf cw
        vt[0]  = '{1'b1,1'b0,3'b010,32'h100,     32'h0,        32'hDEADBEEF,1'b1,1'b0,4'hF,   32'h0,        32'hDEADBEEF,1'b1,1'b0};
        vt[1]  = '{1'b1,1'b0,3'b000,32'h103,     32'h0,        32'h80112233,1'b1,1'b0,4'hF,   32'h0,        32'hFFFFFF80,1'b1,1'b0};
        vt[2]  = '{1'b1,1'b0,3'b100,32'h103,     32'h0,        32'h80112233,1'b1,1'b0,4'hF,   32'h0,        32'h00000080,1'b1,1'b0};
        vt[3]  = '{1'b1,1'b0,3'b001,32'h102,     32'h0,        32'h80112233,1'b1,1'b0,4'hF,   32'h0,        32'hFFFF8011,1'b1,1'b0};
        vt[4]  = '{1'b1,1'b0,3'b101,32'h100,     32'h0,        32'h80112233,1'b1,1'b0,4'hF,   32'h0,        32'h00002233,1'b1,1'b0};
        vt[5]  = '{1'b1,1'b0,3'b000,32'h101,     32'h0,        32'h80112233,1'b1,1'b0,4'hF,   32'h0,        32'h00000022,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b1,3'b000,32'h201,     32'h000000A5, 32'h0,       1'b0,1'b0,4'b0010,32'hA5A5A5A5,32'h201,     1'b0,1'b1};
        vt[7]  = '{1'b0,1'b1,3'b001,32'h202,     32'h1234BEEF, 32'h0,       1'b0,1'b0,4'b1100,32'hBEEFBEEF,32'h202,     1'b0,1'b1};
        vt[8]  = '{1'b0,1'b1,3'b010,32'h204,     32'hCAFEF00D, 32'h0,       1'b0,1'b0,4'hF,   32'hCAFEF00D,32'h204,     1'b0,1'b1};
        vt[9]  = '{1'b1,1'b0,3'b010,32'h102,     32'h0,        32'hDEADBEEF,1'b1,1'b1,4'h0,   32'h0,        32'h0,       1'b0,1'b0};
        vt[10] = '{1'b1,1'b0,3'b001,32'h101,     32'h0,        32'hDEADBEEF,1'b1,1'b1,4'h0,   32'h0,        32'h0,       1'b0,1'b0};
        vt[11] = '{1'b1,1'b0,3'b011,32'h102,     32'h0,        32'hDEADBEEF,1'b1,1'b1,4'h0,   32'h0,        32'h0,       1'b0,1'b0};
        vt[12] = '{1'b0,1'b0,3'b000,32'h12345678,32'h0,        32'h0,       1'b1,1'b0,4'h0,   32'h0,        32'h12345678,1'b1,1'b0};
        vt[13] = '{1'b0,1'b1,3'b001,32'h200,     32'h0000CAFE, 32'h0,       1'b0,1'b0,4'b0011,32'hCAFECAFE,32'h200,     1'b0,1'b1};
        vt[14] = '{1'b0,1'b1,3'b010,32'h206,     32'h11111111, 32'h0,       1'b0,1'b1,4'h0,   32'h0,        32'h0,       1'b0,1'b1};

        repeat (2) tick();
        chk("rst_wbk_data", wbk_data_wb, 32'h0);
        chk("rst_wb2", wbk_data_wb2, 32'h0);
        chk("rst_rd_adr", {27'd0, rd_adr_wb}, 32'h0);
        chk("rst_wbk_rd", {31'd0, wbk_rd_reg_wb}, 32'h0);
        chk("rst_req", {31'd0, dmem_req}, 32'h0);
        chk("rst_dc_stall", {31'd0, dc_stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Table: zero-wait memory, no global stall.
        for (int i = 0; i < 15; i++) begin
            drive_op(vt[i].ld, vt[i].st, vt[i].code, vt[i].adr, vt[i].sd, vt[i].wbk, 5'(i + 1));
            dmem_ack = 1'b1; dmem_rdata = vt[i].rdat;
            memop = (vt[i].ld | vt[i].st) & ~vt[i].mis;
            @(negedge clk);
            chk($sformatf("vec%0d_mis", i), {31'd0, ma_misalign}, {31'd0, vt[i].mis});
            chk($sformatf("vec%0d_req", i), {31'd0, dmem_req}, {31'd0, memop});
            chk($sformatf("vec%0d_we", i), {31'd0, dmem_we}, {31'd0, memop & vt[i].st});
            chk($sformatf("vec%0d_be", i), {28'd0, dmem_be}, {28'd0, vt[i].be});
            chk($sformatf("vec%0d_adr", i), {2'd0, dmem_adr}, memop ? {2'd0, vt[i].adr[31:2]} : 32'h0);
            chk($sformatf("vec%0d_dc_stall", i), {31'd0, dc_stall}, 32'h0);
            if (vt[i].cw) chk($sformatf("vec%0d_wdata", i), dmem_wdata, vt[i].wd);
            tick();
            chk($sformatf("vec%0d_wbk_rd", i), {31'd0, wbk_rd_reg_wb}, {31'd0, vt[i].rdf});
            chk($sformatf("vec%0d_rd_adr", i), {27'd0, rd_adr_wb}, 32'(i + 1));
            if (!vt[i].mis) chk($sformatf("vec%0d_wbk_data", i), wbk_data_wb, vt[i].wv);
        end

        // Randomized ops with 0..3 wait cycles against the reference model.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       begin rl = 1'b1; rs = 1'b0; rcode = 3'($urandom_range(0, 7)); end
                1:       begin rl = 1'b0; rs = 1'b1; rcode = 3'($urandom_range(0, 3)); end
                default: begin rl = 1'b0; rs = 1'b0; rcode = 3'($urandom_range(0, 7)); end
            endcase
            radr = $urandom;
            if ($urandom_range(0, 1) == 1) radr[1:0] = 2'b00;
            rsd = $urandom; rdat = $urandom; rwbk = 1'($urandom); rrd = 5'($urandom);
            lat = $urandom_range(0, 3);
            model(rl, rs, rcode, radr, rsd, rdat, rwbk, rmis, rbe, rwd, rwv, rrdf);
            memop = (rl | rs) & ~rmis;
            ncyc = memop ? lat + 1 : 1;
            prev_wb = wbk_data_wb;
            nstall = 0;
            drive_op(rl, rs, rcode, radr, rsd, rwbk, rrd);
            for (int c = 0; c < ncyc; c++) begin
                dmem_ack   = memop ? (c == lat) : 1'($urandom);
                dmem_rdata = (c == ncyc - 1) ? rdat : $urandom;
                @(negedge clk);
                if (dc_stall) nstall++;
                if (c == ncyc - 1) begin
                    chk($sformatf("rnd%0d_be", n), {28'd0, dmem_be}, {28'd0, rbe});
                    chk($sformatf("rnd%0d_req", n), {31'd0, dmem_req}, {31'd0, memop});
                    if (memop && rs) chk($sformatf("rnd%0d_wdata", n), dmem_wdata, rwd);
                end
                tick();
                if (c < ncyc - 1) chk($sformatf("rnd%0d_hold", n), wbk_data_wb, prev_wb);
            end
            chk($sformatf("rnd%0d_stall_cycles", n), 32'(nstall), memop ? 32'(lat) : 32'h0);
            chk($sformatf("rnd%0d_wbk_rd", n), {31'd0, wbk_rd_reg_wb}, {31'd0, rrdf});
            chk($sformatf("rnd%0d_wb2", n), wbk_data_wb2, prev_wb);
            if (!rmis) chk($sformatf("rnd%0d_wbk_data", n), wbk_data_wb, rwv);
        end

        // LW with ack on the fourth cycle: three stall cycles, stable request.
        drive_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd7);
        prev_wb = wbk_data_wb;
        dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dmem_rdata = $urandom;
            @(negedge clk);
            chk("lw3_dc_stall", {31'd0, dc_stall}, 32'h1);
            chk("lw3_adr", {2'd0, dmem_adr}, 32'h100);
            chk("lw3_be", {28'd0, dmem_be}, 32'hF);
            chk("lw3_req", {31'd0, dmem_req}, 32'h1);
            tick();
            chk("lw3_hold", wbk_data_wb, prev_wb);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h5A5A1234;
        @(negedge clk);
        chk("lw3_ack_dc_stall", {31'd0, dc_stall}, 32'h0);
        tick();
        chk("lw3_data", wbk_data_wb, 32'h5A5A1234);
        drive_op(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 1'b1, 5'd3);
        tick();
        chk("lw3_next_instr", wbk_data_wb, 32'h77);
        chk("lw3_next_wb2", wbk_data_wb2, 32'h5A5A1234);

        // Store acked under global stall: exactly one handshake.
        drive_op(1'b0, 1'b1, 3'b010, 32'h500, 32'h01020304, 1'b0, 5'd0);
        dmem_ack = 1'b1; nhs = 0;
        for (int c = 0; c < 4; c++) begin
            stall = (c < 2);
            if (c == 3) drive_op(1'b0, 1'b0, 3'b000, 32'h88, 32'h0, 1'b1, 5'd4);
            @(negedge clk);
            if (dmem_req && dmem_ack) nhs++;
            if (c == 1) chk("st_done_req", {31'd0, dmem_req}, 32'h0);
            if (c == 0) chk("st_dc_stall", {31'd0, dc_stall}, 32'h0);
            tick();
        end
        chk("st_handshakes", 32'(nhs), 32'h1);
        chk("st_after_wbk", wbk_data_wb, 32'h88);

        // Load acked under global stall: data comes from the captured word.
        drive_op(1'b1, 1'b0, 3'b001, 32'h502, 32'h0, 1'b1, 5'd9);
        prev_wb = wbk_data_wb;
        for (int c = 0; c < 3; c++) begin
            stall = (c < 2);
            dmem_ack = 1'b1;
            dmem_rdata = (c == 0) ? 32'h80010000 : 32'hFFFFFFFF - 32'(c);
            @(negedge clk);
            if (c == 1) chk("ldh_done_req", {31'd0, dmem_req}, 32'h0);
            tick();
            if (c < 2) chk("ldh_hold", wbk_data_wb, prev_wb);
        end
        chk("ldh_data", wbk_data_wb, 32'hFFFF8001);
        chk("ldh_rd", {27'd0, rd_adr_wb}, 32'd9);

        // Flush in the middle of a pending load.
        drive_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 1'b1, 5'd11);
        dmem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("flush_wait_dc_stall", {31'd0, dc_stall}, 32'h1);
            tick();
        end
        rst_pipe = 1'b1;
        tick();
        rst_pipe = 1'b0;
        drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("flush_rd_adr", {27'd0, rd_adr_wb}, 32'h0);
        chk("flush_wbk_rd", {31'd0, wbk_rd_reg_wb}, 32'h0);
        chk("flush_wbk_data", wbk_data_wb, 32'h0);
        chk("flush_wb2", wbk_data_wb2, 32'h0);
        @(negedge clk);
        chk("flush_dc_stall", {31'd0, dc_stall}, 32'h0);
        tick();
        drive_op(1'b1, 1'b0, 3'b010, 32'h604, 32'h0, 1'b1, 5'd12);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("post_flush_req", {31'd0, dmem_req}, 32'h1);
        chk("post_flush_dc_stall", {31'd0, dc_stall}, 32'h0);
        tick();
        chk("post_flush_data", wbk_data_wb, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
